vp_bin_bbox: RTL
================

VP_BIN_BBOX -- requirements
Module: vp_bin_bbox

Interface
REQ-001 Parameter DW, default 8: bits per colour channel, legal range 8..12.
REQ-002 Parameter XW, default 11: column counter width.
REQ-003 Parameter YW, default 11: row counter width.
REQ-004 Parameter OVL_COLOR, default {DW{1}},{DW{0}},{DW{0}} (red): bounding-box overlay colour.
REQ-005 clk  in  1  pixel clock; the only clock.
REQ-006 rst_n  in  1  reset, asynchronous and active-low.
REQ-007 de_in, h_sync_in, v_sync_in  in  1 each  video timing inputs; sync signals are active-high.
REQ-008 pixel_in  in  3*DW  RGB pixel, packed {R,G,B}.
REQ-009 sw  in  2  mode select: 0 passthrough, 1 YCbCr, 2 binary mask, 3 mask with bounding-box overlay.
REQ-010 cb_lo, cb_hi, cr_lo, cr_hi  in  DW each  binarisation thresholds.
REQ-011 pixel_out  out  3*DW  processed pixel.
REQ-012 de_out, h_sync_out, v_sync_out  out  1 each  timing outputs, aligned with pixel_out.
REQ-013 bbox_xmin, bbox_xmax  out  XW each; bbox_ymin, bbox_ymax  out  YW each  bounding box of the last completed frame.
REQ-014 fg_count  out  XW+YW  foreground pixel count of the last completed frame.
REQ-015 frame_done  out  1  one-cycle pulse when bbox/fg_count are updated.

Function
REQ-016 Latency from any input to pixel_out/de_out/h_sync_out/v_sync_out SHALL be exactly 4 cycles in every mode: 3 cycles for the conversion stage and 1 cycle for the output register.
REQ-017 Conversion (BT.601, 8 fractional bits, +128 rounding) SHALL compute Y=16s+(66R+129G+25B)>>8, Cb=128s+(-38R-74G+112B)>>8, Cr=128s+(112R-94G-18B)>>8, where s=2^(DW-8); each result is saturated to [0, 2^DW-1].
REQ-018 Mode 1 output SHALL be {Y,Cb,Cr}.
REQ-019 Pixel is foreground iff cb_lo<Cb<cb_hi and cr_lo<Cr<cr_hi, with strict comparisons.
REQ-020 Mode 2 output: all-ones on all channels for foreground, zero otherwise.
REQ-021 Mode 3 output: the mode-2 pixel, replaced by OVL_COLOR on the border of the previous frame's box (x in {xmin,xmax} with ymin<=y<=ymax, or y in {ymin,ymax} with xmin<=x<=xmax); no overlay while bbox_valid=0.
REQ-022 Mode 0 output: pixel_in delayed by 4 cycles.
REQ-023 Frame start = rising edge of v_sync at the converted stage; sw and the four thresholds SHALL be sampled only at frame start and held for the whole frame.
REQ-024 Column x: reset to 0 at frame start and on each de falling edge; increments after each de-high pixel.
REQ-025 Row y: reset to 0 at frame start; increments on each de falling edge.
REQ-026 Accumulators (xmin, xmax, ymin, ymax, count) SHALL be reset at frame start to xmin/ymin=all-ones, xmax/ymax=0, count=0, and updated on every de-high foreground pixel.
REQ-027 At frame start, the previous frame's accumulators SHALL be copied to the outputs and frame_done pulsed; bbox_valid (internal) = previous count != 0.
REQ-028 An empty frame SHALL output fg_count=0, bbox_xmin/ymin=all-ones, bbox_xmax/ymax=0, and suppress the overlay in the next frame.
REQ-029 Counters and count SHALL saturate at all-ones; they do not wrap.
REQ-030 A pixel arriving in the same cycle as frame start belongs to the new frame.
REQ-031 The first frame start after reset SHALL NOT pulse frame_done.

Reset
REQ-032 While rst_n=0: all outputs, pipeline registers, counters, and latched sw/thresholds = 0; bbox outputs = empty-frame values; frame_done=0.
REQ-033 Reset deasserted mid-frame: outputs stay in mode 0 with zero thresholds until the next frame start.

Structure
REQ-034 The shared package vp_pkg SHALL hold the mode enumeration, the BT.601 coefficient constants and the LAT_CONV=3 constant.
REQ-035 Conversion SHALL be the sub-module vp_ycbcr_conv (DW-parametrised, 3-stage, passes de/syncs alongside).

Verification
REQ-036 Mode 1, DW=8, RGB (255,0,0) -> {Y,Cb,Cr}=(82,90,240) exactly 4 cycles later, with syncs aligned.
REQ-037 Mode 2, thresholds 105/130/122/255, 10x10 frame with a foreground block spanning x 3..5, y 2..4 -> next frame_done gives bbox (3,5,2,4) and fg_count=9.
REQ-038 Mode 3, following frame -> OVL_COLOR exactly on the box border pixels; interior and all other pixels unchanged from mode 2.
REQ-039 sw changed mid-frame -> output mode changes only at the next v_sync rising edge.
REQ-040 All-background frame -> fg_count=0, empty bbox values, and no overlay in the next frame.
REQ-041 rst_n asserted mid-line -> all outputs 0 immediately (asynchronously); first post-reset frame start produces no frame_done.

Source files
------------

// File: rtl/vp_pkg.sv
// Shared definitions for the YCbCr binarisation / bounding-box video pipeline.
package vp_pkg;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_YCBCR = 2'd1,
    MODE_MASK  = 2'd2,
    MODE_BBOX  = 2'd3
  } vp_mode_e;

  localparam int LAT_CONV = 3;

  // BT.601 coefficients with 8 fractional bits
  localparam int Y_R  = 66;
  localparam int Y_G  = 129;
  localparam int Y_B  = 25;
  localparam int CB_R = -38;
  localparam int CB_G = -74;
  localparam int CB_B = 112;
  localparam int CR_R = 112;
  localparam int CR_G = -94;
  localparam int CR_B = -18;
  localparam int CONV_FRAC  = 8;
  localparam int CONV_ROUND = 128;

endpackage

// File: rtl/vp_ycbcr_conv.sv
// Three-stage RGB to YCbCr converter; timing signals travel alongside the pixel.
module vp_ycbcr_conv
  import vp_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3*DW-1:0] pixel_in,
  input  logic            de_in,
  input  logic            h_sync_in,
  input  logic            v_sync_in,
  output logic [DW-1:0]   y_out,
  output logic [DW-1:0]   cb_out,
  output logic [DW-1:0]   cr_out,
  output logic            de_out,
  output logic            h_sync_out,
  output logic            v_sync_out
);

  // Sum magnitude stays below 2^(DW+8); two guard bits cover sign and rounding.
  localparam int SW = DW + 10;
  localparam logic signed [SW-1:0] K_YR  = SW'(Y_R);
  localparam logic signed [SW-1:0] K_YG  = SW'(Y_G);
  localparam logic signed [SW-1:0] K_YB  = SW'(Y_B);
  localparam logic signed [SW-1:0] K_CBR = SW'(CB_R);
  localparam logic signed [SW-1:0] K_CBG = SW'(CB_G);
  localparam logic signed [SW-1:0] K_CBB = SW'(CB_B);
  localparam logic signed [SW-1:0] K_CRR = SW'(CR_R);
  localparam logic signed [SW-1:0] K_CRG = SW'(CR_G);
  localparam logic signed [SW-1:0] K_CRB = SW'(CR_B);
  localparam logic signed [SW-1:0] RND   = SW'(CONV_ROUND);
  localparam logic signed [SW-1:0] OFF_Y = SW'(16 << (DW - 8));
  localparam logic signed [SW-1:0] OFF_C = SW'(128 << (DW - 8));
  localparam logic signed [SW-1:0] MAX_V = SW'((1 << DW) - 1);

  logic [DW-1:0]        r1, g1, b1;
  logic signed [SW-1:0] r_s, g_s, b_s;
  logic signed [SW-1:0] y_sum, cb_sum, cr_sum;
  logic signed [SW-1:0] y_res, cb_res, cr_res;
  logic [2:0]           tim1, tim2;

  function automatic logic [DW-1:0] sat(input logic signed [SW-1:0] v);
    if (v[SW-1]) return '0;
    else if (v > MAX_V) return '1;
    else return v[DW-1:0];
  endfunction

  assign r_s = signed'(SW'(r1));
  assign g_s = signed'(SW'(g1));
  assign b_s = signed'(SW'(b1));

  assign y_res  = (y_sum  >>> CONV_FRAC) + OFF_Y;
  assign cb_res = (cb_sum >>> CONV_FRAC) + OFF_C;
  assign cr_res = (cr_sum >>> CONV_FRAC) + OFF_C;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1         <= '0;
      g1         <= '0;
      b1         <= '0;
      tim1       <= '0;
      y_sum      <= '0;
      cb_sum     <= '0;
      cr_sum     <= '0;
      tim2       <= '0;
      y_out      <= '0;
      cb_out     <= '0;
      cr_out     <= '0;
      de_out     <= 1'b0;
      h_sync_out <= 1'b0;
      v_sync_out <= 1'b0;
    end else begin
      {r1, g1, b1} <= pixel_in;
      tim1         <= {de_in, h_sync_in, v_sync_in};
      y_sum        <= K_YR  * r_s + K_YG  * g_s + K_YB  * b_s + RND;
      cb_sum       <= K_CBR * r_s + K_CBG * g_s + K_CBB * b_s + RND;
      cr_sum       <= K_CRR * r_s + K_CRG * g_s + K_CRB * b_s + RND;
      tim2         <= tim1;
      y_out        <= sat(y_res);
      cb_out       <= sat(cb_res);
      cr_out       <= sat(cr_res);
      {de_out, h_sync_out, v_sync_out} <= tim2;
    end
  end

endmodule

// File: rtl/vp_bin_bbox.sv
// Skin-tone style binarisation with per-frame bounding box, count and box overlay.
module vp_bin_bbox
  import vp_pkg::*;
#(
  parameter int              DW        = 8,
  parameter int              XW        = 11,
  parameter int              YW        = 11,
  parameter logic [3*DW-1:0] OVL_COLOR = {{DW{1'b1}}, {(2*DW){1'b0}}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              de_in,
  input  logic              h_sync_in,
  input  logic              v_sync_in,
  input  logic [3*DW-1:0]   pixel_in,
  input  logic [1:0]        sw,
  input  logic [DW-1:0]     cb_lo,
  input  logic [DW-1:0]     cb_hi,
  input  logic [DW-1:0]     cr_lo,
  input  logic [DW-1:0]     cr_hi,
  output logic [3*DW-1:0]   pixel_out,
  output logic              de_out,
  output logic              h_sync_out,
  output logic              v_sync_out,
  output logic [XW-1:0]     bbox_xmin,
  output logic [XW-1:0]     bbox_xmax,
  output logic [YW-1:0]     bbox_ymin,
  output logic [YW-1:0]     bbox_ymax,
  output logic [XW+YW-1:0]  fg_count,
  output logic              frame_done
);

  logic [3*DW-1:0]  pix_d [LAT_CONV];
  logic [DW-1:0]    c_y, c_cb, c_cr;
  logic             c_de, c_hs, c_vs;
  logic             vs_q, de_q, started, bbox_valid;
  vp_mode_e         mode_q, mode_e;
  logic [DW-1:0]    cb_lo_q, cb_hi_q, cr_lo_q, cr_hi_q;
  logic [DW-1:0]    cb_lo_e, cb_hi_e, cr_lo_e, cr_hi_e;
  logic [XW-1:0]    x_cnt, x_e, x_base, x_nxt, acc_xmin, acc_xmax, nx_xmin, nx_xmax, bx_min_e, bx_max_e;
  logic [YW-1:0]    y_cnt, y_e, y_nxt, acc_ymin, acc_ymax, nx_ymin, nx_ymax, by_min_e, by_max_e;
  logic [XW+YW-1:0] acc_cnt, nx_cnt;
  logic             fs, de_fall, fg, valid_e, on_border;
  logic [3*DW-1:0]  pix_nxt;

  vp_ycbcr_conv #(.DW(DW)) u_conv (
    .clk        (clk),
    .rst_n      (rst_n),
    .pixel_in   (pixel_in),
    .de_in      (de_in),
    .h_sync_in  (h_sync_in),
    .v_sync_in  (v_sync_in),
    .y_out      (c_y),
    .cb_out     (c_cb),
    .cr_out     (c_cr),
    .de_out     (c_de),
    .h_sync_out (c_hs),
    .v_sync_out (c_vs)
  );

  assign fs      = c_vs & ~vs_q;
  assign de_fall = de_q & ~c_de;

  // The pixel coincident with frame start already sees the new frame's settings.
  assign mode_e   = fs ? vp_mode_e'(sw) : mode_q;
  assign cb_lo_e  = fs ? cb_lo : cb_lo_q;
  assign cb_hi_e  = fs ? cb_hi : cb_hi_q;
  assign cr_lo_e  = fs ? cr_lo : cr_lo_q;
  assign cr_hi_e  = fs ? cr_hi : cr_hi_q;
  assign x_e      = fs ? '0 : x_cnt;
  assign y_e      = fs ? '0 : y_cnt;
  assign bx_min_e = fs ? acc_xmin : bbox_xmin;
  assign bx_max_e = fs ? acc_xmax : bbox_xmax;
  assign by_min_e = fs ? acc_ymin : bbox_ymin;
  assign by_max_e = fs ? acc_ymax : bbox_ymax;
  assign valid_e  = fs ? (acc_cnt != '0) : bbox_valid;

  assign fg = (c_cb > cb_lo_e) && (c_cb < cb_hi_e) && (c_cr > cr_lo_e) && (c_cr < cr_hi_e);

  // Box position only has meaning for active pixels, so blanking never gets painted.
  assign on_border = c_de && valid_e &&
                     ((((x_e == bx_min_e) || (x_e == bx_max_e)) && (y_e >= by_min_e) && (y_e <= by_max_e)) ||
                      (((y_e == by_min_e) || (y_e == by_max_e)) && (x_e >= bx_min_e) && (x_e <= bx_max_e)));

  assign x_base = (fs || de_fall) ? '0 : x_cnt;
  assign x_nxt  = (c_de && (x_base != '1)) ? x_base + 1'b1 : x_base;
  assign y_nxt  = fs ? '0 : ((de_fall && (y_cnt != '1)) ? y_cnt + 1'b1 : y_cnt);

  always_comb begin
    nx_xmin = fs ? '1 : acc_xmin;
    nx_xmax = fs ? '0 : acc_xmax;
    nx_ymin = fs ? '1 : acc_ymin;
    nx_ymax = fs ? '0 : acc_ymax;
    nx_cnt  = fs ? '0 : acc_cnt;
    if (c_de && fg) begin
      if (x_e < nx_xmin) nx_xmin = x_e;
      if (x_e > nx_xmax) nx_xmax = x_e;
      if (y_e < nx_ymin) nx_ymin = y_e;
      if (y_e > nx_ymax) nx_ymax = y_e;
      if (nx_cnt != '1) nx_cnt = nx_cnt + 1'b1;
    end
  end

  always_comb begin
    pix_nxt = pix_d[LAT_CONV-1];
    case (mode_e)
      MODE_YCBCR: pix_nxt = {c_y, c_cb, c_cr};
      MODE_MASK:  pix_nxt = fg ? '1 : '0;
      MODE_BBOX:  pix_nxt = on_border ? OVL_COLOR : (fg ? '1 : '0);
      default:    pix_nxt = pix_d[LAT_CONV-1];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT_CONV; i++) pix_d[i] <= '0;
      vs_q       <= 1'b0;
      de_q       <= 1'b0;
      started    <= 1'b0;
      bbox_valid <= 1'b0;
      mode_q     <= MODE_PASS;
      cb_lo_q    <= '0;
      cb_hi_q    <= '0;
      cr_lo_q    <= '0;
      cr_hi_q    <= '0;
      x_cnt      <= '0;
      y_cnt      <= '0;
      acc_xmin   <= '1;
      acc_xmax   <= '0;
      acc_ymin   <= '1;
      acc_ymax   <= '0;
      acc_cnt    <= '0;
      pixel_out  <= '0;
      de_out     <= 1'b0;
      h_sync_out <= 1'b0;
      v_sync_out <= 1'b0;
      bbox_xmin  <= '1;
      bbox_xmax  <= '0;
      bbox_ymin  <= '1;
      bbox_ymax  <= '0;
      fg_count   <= '0;
      frame_done <= 1'b0;
    end else begin
      pix_d[0] <= pixel_in;
      for (int i = 1; i < LAT_CONV; i++) pix_d[i] <= pix_d[i-1];
      vs_q     <= c_vs;
      de_q     <= c_de;
      x_cnt    <= x_nxt;
      y_cnt    <= y_nxt;
      acc_xmin <= nx_xmin;
      acc_xmax <= nx_xmax;
      acc_ymin <= nx_ymin;
      acc_ymax <= nx_ymax;
      acc_cnt  <= nx_cnt;
      if (fs) begin
        mode_q     <= vp_mode_e'(sw);
        cb_lo_q    <= cb_lo;
        cb_hi_q    <= cb_hi;
        cr_lo_q    <= cr_lo;
        cr_hi_q    <= cr_hi;
        bbox_xmin  <= acc_xmin;
        bbox_xmax  <= acc_xmax;
        bbox_ymin  <= acc_ymin;
        bbox_ymax  <= acc_ymax;
        fg_count   <= acc_cnt;
        bbox_valid <= (acc_cnt != '0);
        started    <= 1'b1;
      end
      frame_done <= fs & started;
      pixel_out  <= pix_nxt;
      de_out     <= c_de;
      h_sync_out <= c_hs;
      v_sync_out <= c_vs;
    end
  end

endmodule
